// File: rtl/run_ctrl.sv
// run_ctrl: program-run controller for the instruction-fetch PC.
//
// Owns the start/done handshake with the bench, resolves conditional relative
// branches into PC controls, gates architectural writes outside a run, counts
// RUN cycles and taken branches, and stops a runaway program with a timeout.
//
// Parameters:
//   CW       width of the cycle and branch counters
//   TIMEOUT  maximum RUN cycles before a forced stop (1 <= TIMEOUT < 2**CW)
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   start_i          run request (level)
//   halt_i           decoder: current instruction is halt
//   br_valid_i       decoder: current instruction is a relative branch
//   br_cond_i        00 always, 01 if Z, 10 if !Z, 11 if N
//   br_dir_i         1 = forward, 0 = backward
//   br_offset_i      unsigned branch magnitude
//   flag_z_i         registered ALU zero flag
//   flag_n_i         registered ALU negative flag
//   branch_rel_en_o  take the relative jump this cycle
//   target_o         branch magnitude to PC
//   forward_o        jump direction to PC
//   wr_en_o          global write enable for register file / data memory
//   done_o           program finished (halt or timeout), registered
//   timeout_o        program stopped by the cycle limit, registered
//   cycle_count_o    RUN cycles completed in the current or last run
//   branch_count_o   taken branches in the current or last run
module run_ctrl #(
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          halt_i,
  input  logic          br_valid_i,
  input  logic [1:0]    br_cond_i,
  input  logic          br_dir_i,
  input  logic [7:0]    br_offset_i,
  input  logic          flag_z_i,
  input  logic          flag_n_i,
  output logic          branch_rel_en_o,
  output logic [7:0]    target_o,
  output logic          forward_o,
  output logic          wr_en_o,
  output logic          done_o,
  output logic          timeout_o,
  output logic [CW-1:0] cycle_count_o,
  output logic [CW-1:0] branch_count_o
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  // Value of the cycle counter during the last permitted RUN cycle.
  localparam logic [CW-1:0] CycleLast = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic [CW-1:0] branch_q, branch_d;

  logic in_run;
  logic cond_met;
  logic taken;

  assign in_run = (state_q == StRun);

  always_comb begin
    cond_met = 1'b0;
    unique case (br_cond_i)
      2'b00:   cond_met = 1'b1;
      2'b01:   cond_met = flag_z_i;
      2'b10:   cond_met = ~flag_z_i;
      2'b11:   cond_met = flag_n_i;
      default: cond_met = 1'b0;
    endcase
  end

  // Halt suppresses any branch decoded in the same cycle.
  assign taken = in_run & br_valid_i & ~halt_i & cond_met;

  assign branch_rel_en_o = taken;
  assign target_o        = br_offset_i;
  assign forward_o       = br_dir_i;
  assign wr_en_o         = in_run & ~halt_i & ~start_i;
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign cycle_count_o   = cycle_q;
  assign branch_count_o  = branch_q;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    cycle_d   = cycle_q;
    branch_d  = branch_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StArmed;
      end
      StArmed: begin
        // The PC holds while start is high; run begins once it falls.
        if (!start_i) state_d = StRun;
      end
      StRun: begin
        if (start_i) begin
          state_d = StArmed;
        end else begin
          cycle_d = cycle_q + 1'b1;
          if (taken && (branch_q != '1)) branch_d = branch_q + 1'b1;
          if (halt_i) begin
            state_d   = StDone;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (cycle_q == CycleLast) begin
            state_d   = StDone;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (start_i) state_d = StArmed;
      end
      default: state_d = StIdle;
    endcase

    // Arming always starts from a clean slate; in ARMED these are already clear.
    if (state_d == StArmed) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
      cycle_d   = '0;
      branch_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycle_q   <= '0;
      branch_q  <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cycle_q   <= cycle_d;
      branch_q  <= branch_d;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three instances (TIMEOUT 64, 8, 1) share one stimulus
// stream and are each compared every cycle against a behavioural model, with
// directed checks and a condition-table sweep on top.
module tb_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start, halt, valid, dir, fz, fn;
  logic [1:0] cond;
  logic [7:0] off;

  logic        bre [3];
  logic [7:0]  tgt [3];
  logic        fwd [3];
  logic        wre [3];
  logic        dn  [3];
  logic        tmo [3];
  logic [15:0] cc  [3];
  logic [15:0] bc  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lim = (g == 0) ? 64 : ((g == 1) ? 8 : 1);
    run_ctrl #(.CW(16), .TIMEOUT(Lim)) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .halt_i         (halt),
      .br_valid_i     (valid),
      .br_cond_i      (cond),
      .br_dir_i       (dir),
      .br_offset_i    (off),
      .flag_z_i       (fz),
      .flag_n_i       (fn),
      .branch_rel_en_o(bre[g]),
      .target_o       (tgt[g]),
      .forward_o      (fwd[g]),
      .wr_en_o        (wre[g]),
      .done_o         (dn[g]),
      .timeout_o      (tmo[g]),
      .cycle_count_o  (cc[g]),
      .branch_count_o (bc[g])
    );
  end

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 armed (waiting for start to fall), 2 running, 3 finished
  int          phase [3];
  bit          m_done [3];
  bit          m_to [3];
  int          m_cc [3];
  int          m_bc [3];
  int unsigned lim [3] = '{64, 8, 1};

  function automatic bit cond_true(logic [1:0] c, logic z, logic n);
    if (c == 2'd0) return 1'b1;
    if (c == 2'd1) return z;
    if (c == 2'd2) return !z;
    return n;
  endfunction

  function automatic bit m_taken(int i);
    return (phase[i] == 2) && valid && !halt && cond_true(cond, fz, fn);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      phase[i] = 0; m_done[i] = 0; m_to[i] = 0; m_cc[i] = 0; m_bc[i] = 0;
    end
  endtask

  task automatic model_arm(int i);
    phase[i] = 1; m_done[i] = 0; m_to[i] = 0; m_cc[i] = 0; m_bc[i] = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit tk;
      tk = m_taken(i);
      if (phase[i] == 1) begin
        if (!start) phase[i] = 2;
      end else if (phase[i] == 2 && !start) begin
        m_cc[i]++;
        if (tk && m_bc[i] < 65535) m_bc[i]++;
        if (halt) begin
          phase[i] = 3; m_done[i] = 1; m_to[i] = 0;
        end else if (m_cc[i] == int'(lim[i])) begin
          phase[i] = 3; m_done[i] = 1; m_to[i] = 1;
        end
      end else if (start) begin
        model_arm(i);
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      logic [44:0] act, exp;
      bit          ew;
      ew  = (phase[i] == 2) && !halt && !start;
      act = {bre[i], tgt[i], fwd[i], wre[i], dn[i], tmo[i], cc[i], bc[i]};
      exp = {m_taken(i), off, dir, ew, m_done[i], m_to[i], 16'(m_cc[i]), 16'(m_bc[i])};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model dut%0d t=%0t got=%h expected=%h", i, $time, act, exp);
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Called just after a falling edge: apply inputs, settle, compare.
  task automatic drive(logic s, logic h, logic v, logic [1:0] c, logic d, logic [7:0] o,
                       logic z, logic n);
    start = s; halt = h; valid = v; cond = c; dir = d; off = o; fz = z; fn = n;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic plain(logic s, logic h);
    drive(s, h, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  // One Start cycle, then the ARMED cycle; returns at the start of RUN cycle 1.
  task automatic begin_run();
    plain(1'b1, 1'b0);
    plain(1'b0, 1'b0);
  endtask

  typedef struct {
    logic [1:0] c;
    logic       z;
    logic       n;
    logic       exp;
  } vec_t;

  vec_t vecs [16];
  int   ntaken;

  initial begin
    vecs = '{
      '{2'd0, 1'b0, 1'b0, 1'b1}, '{2'd0, 1'b0, 1'b1, 1'b1},
      '{2'd0, 1'b1, 1'b0, 1'b1}, '{2'd0, 1'b1, 1'b1, 1'b1},
      '{2'd1, 1'b0, 1'b0, 1'b0}, '{2'd1, 1'b0, 1'b1, 1'b0},
      '{2'd1, 1'b1, 1'b0, 1'b1}, '{2'd1, 1'b1, 1'b1, 1'b1},
      '{2'd2, 1'b0, 1'b0, 1'b1}, '{2'd2, 1'b0, 1'b1, 1'b1},
      '{2'd2, 1'b1, 1'b0, 1'b0}, '{2'd2, 1'b1, 1'b1, 1'b0},
      '{2'd3, 1'b0, 1'b0, 1'b0}, '{2'd3, 1'b0, 1'b1, 1'b1},
      '{2'd3, 1'b1, 1'b0, 1'b0}, '{2'd3, 1'b1, 1'b1, 1'b1}
    };
    start = 0; halt = 0; valid = 0; cond = 0; dir = 0; off = 0; fz = 0; fn = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'h5a, 1'b0, 1'b0);
    expect_eq("rst_bre", 32'(bre[0]), 32'd0);
    expect_eq("rst_wre", 32'(wre[0]), 32'd0);
    expect_eq("rst_done", 32'(dn[0]), 32'd0);
    expect_eq("rst_cc", 32'(cc[0]), 32'd0);
    expect_eq("rst_tgt", 32'(tgt[0]), 32'h5a);
    tick();

    // Start high 3 cycles with a branch pending: nothing may fire before RUN.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h04, 1'b0, 1'b0);
      expect_eq("armed_bre", 32'(bre[0]), 32'd0);
      expect_eq("armed_wre", 32'(wre[0]), 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h04, 1'b0, 1'b0);
    expect_eq("armed_fall_wre", 32'(wre[0]), 32'd0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, k == 5, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (k < 5) expect_eq("run_wre", 32'(wre[0]), 32'd1);
      tick();
      if (k == 1) begin
        expect_eq("t1_done", 32'(dn[2]), 32'd1);
        expect_eq("t1_timeout", 32'(tmo[2]), 32'd1);
        expect_eq("t1_cc", 32'(cc[2]), 32'd1);
      end
    end
    expect_eq("halt_done", 32'(dn[0]), 32'd1);
    expect_eq("halt_timeout", 32'(tmo[0]), 32'd0);
    expect_eq("halt_cc", 32'(cc[0]), 32'd5);

    // Branch-condition sweep.
    begin_run();
    ntaken = 0;
    foreach (vecs[i]) begin
      drive(1'b0, 1'b0, 1'b1, vecs[i].c, 1'b0, 8'h12, vecs[i].z, vecs[i].n);
      expect_eq($sformatf("cond%0d_z%0d_n%0d", vecs[i].c, vecs[i].z, vecs[i].n),
                32'(bre[0]), 32'(vecs[i].exp));
      expect_eq("sweep_tgt", 32'(tgt[0]), 32'h12);
      expect_eq("sweep_fwd", 32'(fwd[0]), 32'd0);
      ntaken += int'(vecs[i].exp);
      tick();
    end
    expect_eq("sweep_bc", 32'(bc[0]), 32'(ntaken));
    plain(1'b0, 1'b1);

    // Self-loop branch on the TIMEOUT=8 instance.
    begin_run();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      if (k == 7) expect_eq("loop_done_early", 32'(dn[1]), 32'd0);
    end
    expect_eq("loop_done", 32'(dn[1]), 32'd1);
    expect_eq("loop_timeout", 32'(tmo[1]), 32'd1);
    expect_eq("loop_cc", 32'(cc[1]), 32'd8);
    expect_eq("loop_bc", 32'(bc[1]), 32'd8);

    // Halt and branch in the same cycle.
    begin_run();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'h03, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 8'h03, 1'b0, 1'b0);
    expect_eq("hb_bre", 32'(bre[0]), 32'd0);
    expect_eq("hb_wre", 32'(wre[0]), 32'd0);
    tick();
    expect_eq("hb_done", 32'(dn[0]), 32'd1);
    expect_eq("hb_bc", 32'(bc[0]), 32'd2);

    // Abort by re-asserting Start in RUN.
    begin_run();
    for (int k = 0; k < 4; k++) plain(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h01, 1'b0, 1'b0);
    expect_eq("abort_wre", 32'(wre[0]), 32'd0);
    tick();
    expect_eq("abort_cc", 32'(cc[0]), 32'd0);
    expect_eq("abort_done", 32'(dn[0]), 32'd0);
    plain(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) plain(1'b0, 1'b0);
    expect_eq("rerun_cc", 32'(cc[0]), 32'd3);

    // Asynchronous reset between edges with CycleCount=3.
    drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h05, 1'b0, 1'b0);
    expect_eq("pre_rst_bre", 32'(bre[0]), 32'd1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #1;
    expect_eq("async_bre", 32'(bre[0]), 32'd0);
    expect_eq("async_wre", 32'(wre[0]), 32'd0);
    expect_eq("async_cc", 32'(cc[0]), 32'd0);
    model_check();
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h05, 1'b0, 1'b0);
      tick();
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom % 20) == 0, ($urandom % 30) == 0, 1'($urandom), 2'($urandom),
            1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if (($urandom % 400) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        #1 model_check();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
